// File: rtl/sdram_agent_mux_if.sv
// Client and controller-agent signals of the SDRAM agent mux, grouped for drop-in port wiring.
// The slave modport is the mux's view; the master modport is the clients' and controller's view.
interface sdram_agent_mux_if;
  logic        vid_req;
  logic [19:0] vid_addr;
  logic        vid_gnt;
  logic [15:0] vid_data;
  logic        vid_valid;

  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic [15:0] cpu_rdata;
  logic        cpu_valid;

  logic        RdReq;
  logic [19:0] RdAddr;
  logic        RdGnt;
  logic [15:0] RdData;
  logic        RdDataValid;

  logic        WrReq;
  logic [19:0] WrAddr;
  logic [15:0] WrData;
  logic        WrGnt;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           RdGnt, RdData, RdDataValid, WrGnt,
    output vid_gnt, vid_data, vid_valid, cpu_gnt, cpu_rdata, cpu_valid,
           RdReq, RdAddr, WrReq, WrAddr, WrData
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
           RdGnt, RdData, RdDataValid, WrGnt,
    input  vid_gnt, vid_data, vid_valid, cpu_gnt, cpu_rdata, cpu_valid,
           RdReq, RdAddr, WrReq, WrAddr, WrData
  );
endinterface

// File: rtl/sdram_agent_mux.sv
// Merges a video read client and a CPU read/write client onto the SDRAM controller agents,
// with posted CPU writes, in-order read tagging and idle keep-alive dummy reads.
module sdram_agent_mux #(
  parameter int unsigned WFIFO_DEPTH      = 4,
  parameter int unsigned TAG_DEPTH        = 8,
  parameter int unsigned KEEPALIVE_CYCLES = 512
) (
  input  logic             clk,
  input  logic             rst,
  sdram_agent_mux_if.slave bus
);
  localparam int unsigned WAW = $clog2(WFIFO_DEPTH);
  localparam int unsigned TAW = $clog2(TAG_DEPTH);
  localparam int unsigned KAW = $clog2(KEEPALIVE_CYCLES + 1);

  localparam logic [WAW:0]   WF_FULL  = (WAW + 1)'(WFIFO_DEPTH);
  localparam logic [TAW:0]   TAG_FULL = (TAW + 1)'(TAG_DEPTH);
  localparam logic [KAW-1:0] KA_MAX   = KAW'(KEEPALIVE_CYCLES);

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_VID   = 2'd1,
    SRC_CPU   = 2'd2,
    SRC_DUMMY = 2'd3
  } src_e;

  logic [19:0]    wf_addr_q [WFIFO_DEPTH];
  logic [15:0]    wf_data_q [WFIFO_DEPTH];
  logic [WAW-1:0] wf_wp_q, wf_wp_d;
  logic [WAW-1:0] wf_rp_q, wf_rp_d;
  logic [WAW:0]   wf_cnt_q, wf_cnt_d;

  src_e           tag_q [TAG_DEPTH];
  logic [TAW-1:0] tag_wp_q, tag_wp_d;
  logic [TAW-1:0] tag_rp_q, tag_rp_d;
  logic [TAW:0]   tag_cnt_q, tag_cnt_d;

  logic [KAW-1:0] ka_cnt_q, ka_cnt_d;
  logic [11:0]    ka_row_q, ka_row_d;
  logic           cpu_rd_busy_q, cpu_rd_busy_d;

  logic active;
  logic wf_empty, wf_full, wf_push, wf_pop;
  logic tag_empty, tag_full, tag_push, tag_pop;
  logic ka_due, cpu_rd_ok;
  logic rd_gnt, cpu_rd_gnt, cpu_wr_gnt, dummy_gnt;
  src_e rd_sel, tag_head;

  assign active    = ~rst;
  assign wf_empty  = (wf_cnt_q == '0);
  assign wf_full   = (wf_cnt_q == WF_FULL);
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_full  = (tag_cnt_q == TAG_FULL);
  assign ka_due    = (ka_cnt_q == KA_MAX);
  assign tag_head  = tag_q[tag_rp_q];

  // A CPU read never passes a posted write, so it only competes once the write FIFO drains.
  assign cpu_rd_ok = bus.cpu_req & ~bus.cpu_we & wf_empty & ~cpu_rd_busy_q;

  // Read source select, VID > CPU > DUMMY; a full write FIFO masks all reads so writes drain.
  always_comb begin
    rd_sel = SRC_NONE;
    if (active && !wf_full) begin
      if (bus.vid_req)  rd_sel = SRC_VID;
      else if (cpu_rd_ok) rd_sel = SRC_CPU;
      else if (ka_due)  rd_sel = SRC_DUMMY;
    end
  end

  always_comb begin
    bus.RdReq  = (rd_sel != SRC_NONE);
    bus.RdAddr = '0;
    unique case (rd_sel)
      SRC_VID:   bus.RdAddr = bus.vid_addr;
      SRC_CPU:   bus.RdAddr = bus.cpu_addr;
      SRC_DUMMY: bus.RdAddr = {ka_row_q, 8'h00};
      default:   bus.RdAddr = '0;
    endcase
  end

  assign rd_gnt      = bus.RdGnt & bus.RdReq;
  assign tag_push    = rd_gnt;
  assign bus.vid_gnt = rd_gnt & (rd_sel == SRC_VID);
  assign cpu_rd_gnt  = rd_gnt & (rd_sel == SRC_CPU);
  assign dummy_gnt   = rd_gnt & (rd_sel == SRC_DUMMY);
  assign cpu_wr_gnt  = active & bus.cpu_req & bus.cpu_we & ~wf_full;
  assign bus.cpu_gnt = cpu_rd_gnt | cpu_wr_gnt;

  assign wf_push    = cpu_wr_gnt;
  assign bus.WrReq  = active & ~wf_empty;
  assign wf_pop     = bus.WrReq & bus.WrGnt;
  assign bus.WrAddr = bus.WrReq ? wf_addr_q[wf_rp_q] : '0;
  assign bus.WrData = bus.WrReq ? wf_data_q[wf_rp_q] : '0;

  // Return data is routed straight from RdData by the oldest outstanding tag; untagged beats vanish.
  assign tag_pop       = active & bus.RdDataValid & ~tag_empty;
  assign bus.vid_valid = tag_pop & (tag_head == SRC_VID);
  assign bus.cpu_valid = tag_pop & (tag_head == SRC_CPU);
  assign bus.vid_data  = bus.vid_valid ? bus.RdData : '0;
  assign bus.cpu_rdata = bus.cpu_valid ? bus.RdData : '0;

  always_comb begin
    wf_wp_d  = wf_push ? wf_wp_q + WAW'(1) : wf_wp_q;
    wf_rp_d  = wf_pop  ? wf_rp_q + WAW'(1) : wf_rp_q;
    wf_cnt_d = wf_cnt_q;
    if (wf_push && !wf_pop)      wf_cnt_d = wf_cnt_q + (WAW + 1)'(1);
    else if (wf_pop && !wf_push) wf_cnt_d = wf_cnt_q - (WAW + 1)'(1);

    tag_wp_d  = tag_push ? tag_wp_q + TAW'(1) : tag_wp_q;
    tag_rp_d  = tag_pop  ? tag_rp_q + TAW'(1) : tag_rp_q;
    tag_cnt_d = tag_cnt_q;
    if (tag_push && !tag_pop)      tag_cnt_d = tag_cnt_q + (TAW + 1)'(1);
    else if (tag_pop && !tag_push) tag_cnt_d = tag_cnt_q - (TAW + 1)'(1);

    ka_cnt_d = ka_cnt_q;
    if (bus.RdGnt)   ka_cnt_d = '0;
    else if (!ka_due) ka_cnt_d = ka_cnt_q + KAW'(1);

    ka_row_d = dummy_gnt ? ka_row_q + 12'd1 : ka_row_q;

    cpu_rd_busy_d = cpu_rd_busy_q;
    if (cpu_rd_gnt)         cpu_rd_busy_d = 1'b1;
    else if (bus.cpu_valid) cpu_rd_busy_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wf_wp_q       <= '0;
      wf_rp_q       <= '0;
      wf_cnt_q      <= '0;
      tag_wp_q      <= '0;
      tag_rp_q      <= '0;
      tag_cnt_q     <= '0;
      ka_cnt_q      <= '0;
      ka_row_q      <= '0;
      cpu_rd_busy_q <= 1'b0;
    end else begin
      wf_wp_q       <= wf_wp_d;
      wf_rp_q       <= wf_rp_d;
      wf_cnt_q      <= wf_cnt_d;
      tag_wp_q      <= tag_wp_d;
      tag_rp_q      <= tag_rp_d;
      tag_cnt_q     <= tag_cnt_d;
      ka_cnt_q      <= ka_cnt_d;
      ka_row_q      <= ka_row_d;
      cpu_rd_busy_q <= cpu_rd_busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wf_push) begin
      wf_addr_q[wf_wp_q] <= bus.cpu_addr;
      wf_data_q[wf_wp_q] <= bus.cpu_wdata;
    end
    if (tag_push) tag_q[tag_wp_q] <= rd_sel;
  end

  tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(tag_push && tag_full && !tag_pop));
endmodule

// File: tb/tb_sdram_agent_mux.sv
// Directed bench for sdram_agent_mux with a 4-cycle-latency controller model driven per cycle.
module tb_sdram_agent_mux;
  logic clk;
  logic rst;
  sdram_agent_mux_if bus();

  sdram_agent_mux #(
    .WFIFO_DEPTH(4),
    .TAG_DEPTH(8),
    .KEEPALIVE_CYCLES(512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [19:0] a;
    logic [15:0] d;
  } op_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base;
  int vid_left = 0;
  int n_cpu_gnt = 0;
  int cpu_rd_gnt_cyc = -1;
  bit rd_gnt_en = 1'b1;
  bit wr_gnt_en = 1'b0;
  bit          pv [4];
  logic [15:0] pd [4];
  logic [15:0] mem [logic [19:0]];
  op_t         cpu_ops [$];
  logic [19:0] gnt_addr_q [$];
  int          gnt_cyc_q [$];
  logic [15:0] vid_beats [$];
  logic [15:0] cpu_beats [$];
  logic [19:0] wr_addr_log [$];
  logic [15:0] wr_data_log [$];
  int          wr_cyc_log [$];
  logic        s_rdreq, s_vid_gnt, s_cpu_gnt;

  function automatic logic [15:0] rd_model(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    gnt_addr_q.delete(); gnt_cyc_q.delete();
    vid_beats.delete(); cpu_beats.delete();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    n_cpu_gnt = 0;
    cpu_rd_gnt_cyc = -1;
  endtask

  // One clock cycle: controller drives at negedge, observations logged, clients update after posedge.
  task automatic tick();
    op_t op;
    @(negedge clk);
    bus.RdDataValid = pv[0];
    bus.RdData      = pd[0];
    for (int i = 0; i < 3; i++) begin
      pv[i] = pv[i+1];
      pd[i] = pd[i+1];
    end
    pv[3] = 1'b0;
    pd[3] = '0;
    #1;
    bus.RdGnt = rd_gnt_en & bus.RdReq;
    bus.WrGnt = wr_gnt_en & bus.WrReq;
    #1;
    s_rdreq   = bus.RdReq;
    s_vid_gnt = bus.vid_gnt;
    s_cpu_gnt = bus.cpu_gnt;
    if (bus.RdGnt) begin
      pv[3] = 1'b1;
      pd[3] = rd_model(bus.RdAddr);
      gnt_addr_q.push_back(bus.RdAddr);
      gnt_cyc_q.push_back(cyc);
    end
    if (bus.WrGnt) begin
      mem[bus.WrAddr] = bus.WrData;
      wr_addr_log.push_back(bus.WrAddr);
      wr_data_log.push_back(bus.WrData);
      wr_cyc_log.push_back(cyc);
    end
    if (bus.vid_valid) vid_beats.push_back(bus.vid_data);
    if (bus.cpu_valid) cpu_beats.push_back(bus.cpu_rdata);
    if (bus.cpu_gnt) begin
      n_cpu_gnt++;
      if (!bus.cpu_we) cpu_rd_gnt_cyc = cyc;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_vid_gnt) begin
      vid_left--;
      bus.vid_addr = bus.vid_addr + 20'd1;
      bus.vid_req  = (vid_left > 0);
    end
    if (s_cpu_gnt) bus.cpu_req = 1'b0;
    if (!bus.cpu_req && cpu_ops.size() > 0) begin
      op = cpu_ops.pop_front();
      bus.cpu_we    = op.we;
      bus.cpu_addr  = op.a;
      bus.cpu_wdata = op.d;
      bus.cpu_req   = 1'b1;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.vid_req = 1'b0; bus.vid_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.RdGnt = 1'b0; bus.RdData = '0; bus.RdDataValid = 1'b0; bus.WrGnt = 1'b0;
    for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; pd[i] = '0; end

    // Reset state
    ticks(3);
    chk("reset_outputs", 32'({bus.RdReq, bus.WrReq, bus.vid_gnt, bus.cpu_gnt, bus.vid_valid,
                              bus.cpu_valid, bus.RdAddr, bus.WrAddr}), 32'd0);
    rst = 1'b0;
    base = cyc;
    chk("reset_ka_cnt", 32'(dut.ka_cnt_q), 32'd0);

    // Idle keep-alive: first dummy at cycle 512, next 513 cycles later at row 1
    for (int i = 0; i < 1200 && gnt_addr_q.size() < 2; i++) tick();
    chk("ka_gnt_count", 32'(gnt_addr_q.size()), 32'd2);
    if (gnt_addr_q.size() >= 2) begin
      chk("ka_first_cycle", 32'(gnt_cyc_q[0] - base), 32'd512);
      chk("ka_first_addr", 32'(gnt_addr_q[0]), 32'h00000);
      chk("ka_second_cycle", 32'(gnt_cyc_q[1] - base), 32'd1025);
      chk("ka_second_addr", 32'(gnt_addr_q[1]), 32'h00100);
    end
    ticks(6);
    chk("ka_no_valid", 32'(vid_beats.size() + cpu_beats.size()), 32'd0);
    chk("ka_tag_empty", 32'(dut.tag_cnt_q), 32'd0);

    // Video burst of 4 beats ahead of a pending CPU read
    clear_logs();
    bus.vid_addr = 20'h12340; vid_left = 4; bus.vid_req = 1'b1;
    bus.cpu_we = 1'b0; bus.cpu_addr = 20'h00010; bus.cpu_req = 1'b1;
    ticks(12);
    chk("mix_gnt_count", 32'(gnt_addr_q.size()), 32'd5);
    if (gnt_addr_q.size() == 5) begin
      chk("mix_gnt0", 32'(gnt_addr_q[0]), 32'h12340);
      chk("mix_gnt3", 32'(gnt_addr_q[3]), 32'h12343);
      chk("mix_gnt_cpu", 32'(gnt_addr_q[4]), 32'h00010);
    end
    chk("mix_vid_beats", 32'(vid_beats.size()), 32'd4);
    if (vid_beats.size() == 4) begin
      chk("mix_vid_d0", 32'(vid_beats[0]), 32'h791A);
      chk("mix_vid_d1", 32'(vid_beats[1]), 32'h791B);
      chk("mix_vid_d2", 32'(vid_beats[2]), 32'h7918);
      chk("mix_vid_d3", 32'(vid_beats[3]), 32'h7919);
    end
    chk("mix_cpu_beats", 32'(cpu_beats.size()), 32'd1);
    if (cpu_beats.size() == 1) chk("mix_cpu_data", 32'(cpu_beats[0]), 32'h5A4A);
    chk("mix_tag_empty", 32'(dut.tag_cnt_q), 32'd0);
    chk("mix_busy_clear", 32'(dut.cpu_rd_busy_q), 32'd0);

    // Five posted writes with WrGnt stalled: four accepted, reads masked while full
    clear_logs();
    wr_gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) cpu_ops.push_back('{1'b1, 20'h00100 + 20'(i), 16'hD000 + 16'(i)});
    ticks(8);
    chk("wfull_gnt_count", 32'(n_cpu_gnt), 32'd4);
    chk("wfull_occupancy", 32'(dut.wf_cnt_q), 32'd4);
    bus.vid_addr = 20'h00200; vid_left = 1; bus.vid_req = 1'b1;
    ticks(3);
    chk("wfull_rdreq_masked", 32'(s_rdreq), 32'd0);
    chk("wfull_no_rd_gnt", 32'(gnt_addr_q.size()), 32'd0);
    wr_gnt_en = 1'b1;
    ticks(12);
    chk("wfull_drain_count", 32'(wr_addr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_addr_log.size(); i++) begin
      chk("wfull_drain_addr", 32'(wr_addr_log[i]), 32'h00100 + 32'(i));
      chk("wfull_drain_data", 32'(wr_data_log[i]), 32'hD000 + 32'(i));
    end
    chk("wfull_vid_beats", 32'(vid_beats.size()), 32'd1);
    if (vid_beats.size() == 1) chk("wfull_vid_data", 32'(vid_beats[0]), 32'h585A);

    // Read-after-write to the same address waits for the write to leave the FIFO
    clear_logs();
    wr_gnt_en = 1'b0;
    cpu_ops.push_back('{1'b1, 20'h00020, 16'hBEEF});
    cpu_ops.push_back('{1'b0, 20'h00020, 16'h0000});
    ticks(6);
    chk("raw_rd_held", 32'(cpu_rd_gnt_cyc), 32'hFFFF_FFFF);
    chk("raw_rdreq_low", 32'(s_rdreq), 32'd0);
    wr_gnt_en = 1'b1;
    ticks(10);
    chk("raw_wr_count", 32'(wr_cyc_log.size()), 32'd1);
    if (wr_cyc_log.size() == 1) chk("raw_rd_after_wr", 32'(cpu_rd_gnt_cyc > wr_cyc_log[0]), 32'd1);
    chk("raw_cpu_beats", 32'(cpu_beats.size()), 32'd1);
    if (cpu_beats.size() == 1) chk("raw_cpu_data", 32'(cpu_beats[0]), 32'hBEEF);

    // Full FIFO: WrGnt pop blocks the waiting push that cycle, push refills next cycle
    clear_logs();
    wr_gnt_en = 1'b0;
    for (int i = 0; i < 5; i++) cpu_ops.push_back('{1'b1, 20'h00300 + 20'(i), 16'hC000 + 16'(i)});
    ticks(8);
    chk("pp_full", 32'(dut.wf_cnt_q), 32'd4);
    wr_gnt_en = 1'b1;
    tick();
    wr_gnt_en = 1'b0;
    chk("pp_pop_no_gnt", 32'(s_cpu_gnt), 32'd0);
    chk("pp_after_pop", 32'(dut.wf_cnt_q), 32'd3);
    tick();
    chk("pp_refill_gnt", 32'(s_cpu_gnt), 32'd1);
    chk("pp_refilled", 32'(dut.wf_cnt_q), 32'd4);
    wr_gnt_en = 1'b1;
    ticks(10);
    chk("pp_drain_count", 32'(wr_addr_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < wr_addr_log.size(); i++) begin
      chk("pp_drain_addr", 32'(wr_addr_log[i]), 32'h00300 + 32'(i));
      chk("pp_drain_data", 32'(wr_data_log[i]), 32'hC000 + 32'(i));
    end
    chk("pp_gnt_total", 32'(n_cpu_gnt), 32'd5);

    // Reset with three reads in flight: returning beats are dropped
    clear_logs();
    bus.vid_addr = 20'h00400; vid_left = 3; bus.vid_req = 1'b1;
    ticks(3);
    chk("rst_reads_issued", 32'(gnt_addr_q.size()), 32'd3);
    rst = 1'b1;
    ticks(2);
    chk("rst_valid_low", 32'({bus.vid_valid, bus.cpu_valid, bus.RdReq}), 32'd0);
    rst = 1'b0;
    chk("rst_wf_cnt", 32'(dut.wf_cnt_q), 32'd0);
    chk("rst_tag_cnt", 32'(dut.tag_cnt_q), 32'd0);
    chk("rst_ka_cnt", 32'(dut.ka_cnt_q), 32'd0);
    chk("rst_ka_row", 32'(dut.ka_row_q), 32'd0);
    chk("rst_busy", 32'(dut.cpu_rd_busy_q), 32'd0);
    ticks(6);
    chk("rst_stale_dropped", 32'(vid_beats.size() + cpu_beats.size()), 32'd0);
    chk("rst_tag_still_empty", 32'(dut.tag_cnt_q), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
